sram32_arbiter: RTL

//  Shares one sram32 macro (1-cycle registered read) between NP requesters.

---
 rtl/sram32_arb_pkg.sv | 29 ++
 rtl/sram32_rr_pick.sv | 23 ++
 rtl/sram32_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sram32_arb_pkg.sv
// Shared types and helpers for the sram32 arbiter.
// Index width is sized for the widest supported port count (4).
package sram32_arb_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_e;

  localparam int unsigned NP_MAX = 4;
  localparam int unsigned IW     = (NP_MAX > 2) ? 2 : 1;

  // Round-robin search starting at owner+1; the old owner is tried last.
  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0]     owner,
                                            input logic [NP_MAX-1:0] req,
                                            input int unsigned       np);
    logic [IW-1:0] res;
    logic          found;
    int unsigned   cand;
    res   = owner;
    found = 1'b0;
    for (int unsigned k = 1; k <= NP_MAX; k++) begin
      cand = (32'(owner) + k) % np;
      if (!found && (k <= np) && req[cand[IW-1:0]]) begin
        res   = cand[IW-1:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram32_rr_pick.sv
// Combinational round-robin picker: request vector and last owner in,
// winner index and one-hot grant out (one-hot is zero when nothing requests).
module sram32_rr_pick
  import sram32_arb_pkg::*;
#(
  parameter int unsigned NP = 2
) (
  input  logic [NP-1:0] req,
  input  logic [IW-1:0] owner,
  output logic [NP-1:0] onehot,
  output logic [IW-1:0] idx
);

  logic [NP_MAX-1:0] req_x;

  assign req_x = NP_MAX'(req);
  assign idx   = rr_next(owner, req_x, NP);

  for (genvar i = 0; i < NP; i++) begin : g_oh
    assign onehot[i] = (|req) && (idx == IW'(i));
  end

endmodule

// File: rtl/sram32_arbiter.sv
// Round-robin arbiter with per-owner burst limit in front of one sram32 macro.
// Optional SRAM_ARB_LOCK_EN lets an owner hold the grant via req_lock.
module sram32_arbiter
  import sram32_arb_pkg::*;
#(
  parameter int unsigned AW        = 10,
  parameter int unsigned NP        = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NP-1:0]    req,
  input  logic [NP*4-1:0]  req_we,
  input  logic [NP*AW-1:0] req_addr,
  input  logic [NP*32-1:0] req_wdata,
  input  logic [NP-1:0]    req_lock,
  output logic [NP-1:0]    gnt,
  output logic [NP-1:0]    rvalid,
  output logic [31:0]      rdata,
  output logic             sram_cs,
  output logic [3:0]       sram_we,
  output logic [AW-1:0]    sram_a,
  output logic [31:0]      sram_di,
  input  logic [31:0]      sram_do
);

  localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            rd_pend_q, rd_pend_d;
  logic [IW-1:0]   rd_port_q, rd_port_d;

  logic [NP_MAX-1:0] req_x;
  logic [3:0]        we_a   [NP_MAX];
  logic [AW-1:0]     addr_a [NP_MAX];
  logic [31:0]       wd_a   [NP_MAX];

  logic            any_req, own_ok, stay, lock_hold, keep;
  logic [IW-1:0]   pick_idx, win;
  logic [NP-1:0]   pick_oh;

  // Unpack per-port fields; requests are masked while reset is held.
  for (genvar i = 0; i < NP_MAX; i++) begin : g_port
    if (i < NP) begin : g_used
      assign req_x[i]  = req[i] & rst_n;
      assign we_a[i]   = req_we[4*i +: 4];
      assign addr_a[i] = req_addr[AW*i +: AW];
      assign wd_a[i]   = req_wdata[32*i +: 32];
    end else begin : g_pad
      assign req_x[i]  = 1'b0;
      assign we_a[i]   = 4'h0;
      assign addr_a[i] = '0;
      assign wd_a[i]   = '0;
    end
  end

  sram32_rr_pick #(.NP(NP)) u_pick (
    .req    (req_x[NP-1:0]),
    .owner  (owner_q),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  assign any_req = |req_x;
  assign own_ok  = (state_q == ST_OWN) && req_x[owner_q];
  assign stay    = own_ok && (MAX_BURST > 1) && ((32'(burst_q) + 32'd1) < MAX_BURST);

`ifdef SRAM_ARB_LOCK_EN
  logic [NP_MAX-1:0] lock_x;
  logic              lock_q, lock_d;

  assign lock_x    = NP_MAX'(req_lock);
  assign lock_hold = own_ok && lock_q;
`else
  logic unused_lock;

  assign unused_lock = ^req_lock;
  assign lock_hold   = 1'b0;
`endif

  assign keep = lock_hold || stay;
  assign win  = keep ? owner_q : pick_idx;

  for (genvar i = 0; i < NP; i++) begin : g_out
    assign gnt[i]    = keep ? (owner_q == IW'(i)) : pick_oh[i];
    assign rvalid[i] = rd_pend_q && (rd_port_q == IW'(i));
  end

  assign sram_cs = any_req;
  assign sram_we = any_req ? we_a[win] : 4'h0;
  assign sram_a  = addr_a[win];
  assign sram_di = wd_a[win];
  assign rdata   = sram_do;

  // Next-state: owner tracking, burst counting and read-return bookkeeping.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    burst_d   = burst_q;
    rd_pend_d = 1'b0;
    rd_port_d = rd_port_q;
`ifdef SRAM_ARB_LOCK_EN
    lock_d    = 1'b0;
`endif
    if (any_req) begin
      state_d   = ST_OWN;
      owner_d   = win;
      rd_pend_d = (we_a[win] == 4'h0);
      rd_port_d = win;
      if ((state_q == ST_OWN) && (win == owner_q)) begin
        if ((32'(burst_q) + 32'd1) < MAX_BURST) burst_d = burst_q + BW'(1);
      end else begin
        burst_d = '0;
      end
`ifdef SRAM_ARB_LOCK_EN
      lock_d = lock_x[win];
`endif
    end else begin
      state_d = ST_IDLE;
      burst_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= IW'(NP - 1);
      burst_q   <= '0;
      rd_pend_q <= 1'b0;
      rd_port_q <= '0;
`ifdef SRAM_ARB_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
`ifdef SRAM_ARB_LOCK_EN
      lock_q    <= lock_d;
`endif
    end
  end

endmodule
